// File: rtl/alu_arbiter_if.sv
// Requester, ALU and trap signals between alu_arbiter and its environment.
// ALU_ARB_LOCK_EN adds the per-requester lock inputs.
interface alu_arbiter_if #(
  parameter int WIDTH = 20,
  parameter int OPW   = 4
);
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic             req0_setflags, req1_setflags, req0_sign, req1_sign;
`ifdef ALU_ARB_LOCK_EN
  logic             req0_lock, req1_lock;
`endif
  logic             rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp_data, alu_in1, alu_in2, alu_out;
  logic [OPW-1:0]   alu_op;
  logic             sign_mode, status_we, trap, trap_ack, busy;

  modport master (
`ifdef ALU_ARB_LOCK_EN
    output req0_lock, req1_lock,
`endif
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output req0_op, req1_op, req0_setflags, req1_setflags, req0_sign, req1_sign,
    output alu_out, trap,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
    input  alu_in1, alu_in2, alu_op, sign_mode, status_we, trap_ack, busy
  );

  modport slave (
`ifdef ALU_ARB_LOCK_EN
    input  req0_lock, req1_lock,
`endif
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  req0_op, req1_op, req0_setflags, req1_setflags, req0_sign, req1_sign,
    input  alu_out, trap,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
    output alu_in1, alu_in2, alu_op, sign_mode, status_we, trap_ack, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ALU and the status-register path
// between two requesters. Optional ALU_ARB_LOCK_EN lets an owner pin the grant.
module alu_arbiter #(
  parameter int WIDTH   = 20,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  alu_arbiter_if.slave bus
);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic             sign;
    logic             setflags;
  } req_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             owner, ptr, flag_q, sign_q;
  logic [WIDTH-1:0] in1_q, in2_q, rsp_q;
  logic [OPW-1:0]   op_q;
  req_t [1:0]       req;
  req_t             sel;
  logic [1:0]       vld;
  logic             grant, winner, pick, lock_hon;

  assign req[0] = {bus.req0_a, bus.req0_b, bus.req0_op, bus.req0_sign, bus.req0_setflags};
  assign req[1] = {bus.req1_a, bus.req1_b, bus.req1_op, bus.req1_sign, bus.req1_setflags};
  assign vld    = {bus.req1_valid, bus.req0_valid};
  assign sel    = req[winner];

`ifdef ALU_ARB_LOCK_EN
  logic [1:0] lock;
  logic       lock_held, lock_owner;
  assign lock = {bus.req1_lock, bus.req0_lock};
  // A held lock yields the contention as soon as its owner drops lock.
  assign pick = lock_held ? (lock[lock_owner] ? lock_owner : ~lock_owner) : ptr;
  assign lock_hon = lock[winner] && (!lock_held || winner == lock_owner);
`else
  assign pick     = ptr;
  assign lock_hon = 1'b0;
`endif

  // Grant is gated by reset so ready stays low while reset is held.
  assign grant  = reset && (state == IDLE) && !bus.trap && (|vld);
  assign winner = (&vld) ? pick : vld[1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = EXEC;
      EXEC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      owner  <= 1'b0;
      ptr    <= 1'b0;
      flag_q <= 1'b0;
      sign_q <= 1'b0;
      in1_q  <= '0;
      in2_q  <= '0;
      op_q   <= '0;
      rsp_q  <= '0;
`ifdef ALU_ARB_LOCK_EN
      lock_held  <= 1'b0;
      lock_owner <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= (state == EXEC && cnt != LAST) ? cnt + 1'b1 : '0;
      if (state == EXEC && cnt == LAST) rsp_q <= bus.alu_out;
      if (grant) begin
        in1_q  <= sel.a;
        in2_q  <= sel.b;
        op_q   <= sel.op;
        sign_q <= sel.sign;
        flag_q <= sel.setflags;
        owner  <= winner;
        ptr    <= lock_hon ? winner : ~winner;
`ifdef ALU_ARB_LOCK_EN
        lock_held  <= lock_hon;
        lock_owner <= winner;
`endif
      end
    end
  end

  assign bus.req0_ready = grant && !winner;
  assign bus.req1_ready = grant && winner;
  assign bus.rsp0_valid = (state == DONE) && !owner;
  assign bus.rsp1_valid = (state == DONE) && owner;
  assign bus.status_we  = (state == DONE) && flag_q;
  assign bus.busy       = (state != IDLE);
  assign bus.trap_ack   = reset && bus.trap && (state == IDLE);
  assign bus.rsp_data   = rsp_q;
  assign bus.alu_in1    = in1_q;
  assign bus.alu_in2    = in2_q;
  assign bus.alu_op     = op_q;
  assign bus.sign_mode  = sign_q;
endmodule
